stf_gen: RTL and testbench
==========================

STF_GEN -- requirements
Module: stf_gen

Interface
REQ-001 Parameter NUM_REP, default 10, number of 16-sample STF periods emitted per burst (legal 1..15).
REQ-002 Parameter WIN_EN, default 1; 1 halves the first sample and appends one halved tail sample, 0 emits raw periods only.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 phy_tx_arest  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse requesting one STF burst.
REQ-006 stf_addr  output  4  address to external STF ROM.
REQ-007 stf_dout  input  32  ROM word {I[31:16], Q[15:0]}, signed 16-bit each, combinational from stf_addr.
REQ-008 out_data  output  32  sample {I,Q} to downstream stage.
REQ-009 out_valid  output  1  out_data holds a valid sample.
REQ-010 out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready at a rising clk edge.
REQ-011 busy  output  1  high from accepted start until the last transfer.
REQ-012 done  output  1  one-cycle pulse in the cycle after the last transfer.

Function
REQ-013 States SHALL be IDLE, RUN, FLUSH; reset state IDLE.
REQ-014 IDLE: start=1 SHALL load sample counter cnt=0, present sample 0 on out_data with out_valid=1 on the next edge, and go to RUN.
REQ-015 Burst length SHALL be L = NUM_REP*16 + WIN_EN samples; cnt width is 8 bits.
REQ-016 stf_addr SHALL equal cnt[3:0] of the sample being fetched; the ROM word SHALL be registered into out_data (one-cycle fetch latency, no combinational path from stf_dout to out_data).
REQ-017 With WIN_EN=1, sample 0 and sample L-1 SHALL have I and Q each arithmetically shifted right by 1 (sign-preserving); all other samples pass unmodified.
REQ-018 On each transfer with cnt < L-1, cnt SHALL increment and the next sample SHALL be on out_data on the following edge with out_valid kept high (full throughput, one sample per cycle under continuous out_ready).
REQ-019 While out_valid=1 and out_ready=0, out_data, out_valid and cnt SHALL hold stable.
REQ-020 Transfer of sample L-1 SHALL move to FLUSH, drop out_valid and busy on the next edge; FLUSH SHALL assert done for exactly one cycle and return to IDLE.
REQ-021 start while busy=1 or in FLUSH SHALL be ignored (not queued).
REQ-022 start in IDLE SHALL set busy=1 on the next edge; a new start in the cycle after done SHALL be accepted.
REQ-023 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-024 Assertion of phy_tx_arest SHALL immediately force state IDLE, cnt=0, stf_addr=0, out_data=0, out_valid=0, busy=0, done=0, including mid-burst; no partial burst resumes after release.
REQ-025 First start accepted SHALL be one sampled on the first rising edge after phy_tx_arest deasserts.

Structure
REQ-026 Shared package SHALL hold the state enum, STF_PERIOD=16, SAMPLE_W=16 and a halve-sample function (per-component arithmetic shift right by 1).
REQ-027 No sub-module; the STF ROM is instantiated by the parent and connected via stf_addr/stf_dout.

Verification
REQ-028 Reset: assert phy_tx_arest with start=1 -> out_valid=0, out_data=0, busy=0, done=0, stf_addr=0.
REQ-029 Default parameters, out_ready=1, start pulse -> 161 transfers on consecutive cycles; sample0=0179_0179, sample1=fbd6_0000, sample2=02f2_fd0e, sample16=02f2_02f2, sample160=0179_0179; done one cycle after sample160.
REQ-030 Backpressure: out_ready=0 for 3 cycles while sample5 (042a_0000) is presented -> out_data stays 042a_0000, out_valid stays 1; sample6=fd0e_02f2 follows when out_ready=1.
REQ-031 start pulsed at sample 40 of a burst -> ignored; exactly 161 transfers, one done pulse.
REQ-032 phy_tx_arest pulsed at sample 70 -> outputs zero immediately; new start after release -> sample0=0179_0179, full 161-sample burst.
REQ-033 WIN_EN=0, NUM_REP=2 -> 32 transfers, sample0=02f2_02f2, sample31=0000_fbd6, no halved samples.

Source files
------------

// File: rtl/stf_gen_pkg.sv
// stf_gen_pkg: shared types, constants and sample helper for the STF generator
package stf_gen_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
  localparam int STF_PERIOD = 16;
  localparam int SAMPLE_W = 16;
  function automatic logic [2*SAMPLE_W-1:0] halve(input logic [2*SAMPLE_W-1:0] s);
    logic signed [SAMPLE_W-1:0] i, q;
    i = $signed(s[2*SAMPLE_W-1:SAMPLE_W]) >>> 1;
    q = $signed(s[SAMPLE_W-1:0]) >>> 1;
    return {i, q};
  endfunction
endpackage

// File: rtl/stf_gen.sv
// stf_gen: streams NUM_REP STF periods from an external ROM with optional edge windowing
module stf_gen
  import stf_gen_pkg::*;
#(
  parameter int NUM_REP = 10,
  parameter int WIN_EN = 1
) (
  input  logic        clk,
  input  logic        phy_tx_arest,
  input  logic        start,
  output logic [3:0]  stf_addr,
  input  logic [31:0] stf_dout,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);
  localparam logic [7:0] LAST = 8'(NUM_REP * STF_PERIOD + WIN_EN - 1);
  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  fi;
  logic [31:0] smp;
  // index of the sample fetched this cycle and its windowed value
  always_comb begin
    fi = (state == RUN) ? cnt + 8'd1 : 8'd0;
    smp = (WIN_EN != 0 && (fi == 8'd0 || fi == LAST)) ? halve(stf_dout) : stf_dout;
  end
  assign stf_addr = fi[3:0];
  assign out_valid = state == RUN;
  assign busy = state == RUN;
  assign done = state == FLUSH;
  // burst sequencing and registered ROM fetch
  always_ff @(posedge clk or posedge phy_tx_arest) begin
    if (phy_tx_arest) begin
      state <= IDLE;
      cnt <= 8'd0;
      out_data <= 32'd0;
    end else if (state == IDLE && start) begin
      state <= RUN;
      cnt <= 8'd0;
      out_data <= smp;
    end else if (state == RUN && out_ready && cnt == LAST) begin
      state <= FLUSH;
      out_data <= 32'd0;
    end else if (state == RUN && out_ready) begin
      cnt <= fi;
      out_data <= smp;
    end else if (state == FLUSH) begin
      state <= IDLE;
      cnt <= 8'd0;
    end
  end
endmodule

// File: tb/tb_stf_gen.sv
// tb_stf_gen: scoreboard bench for stf_gen with default and unwindowed instances
module tb_stf_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start1 = 1'b0;
  logic        out_ready = 1'b1, ready1 = 1'b1;
  logic [3:0]  addr0, addr1;
  logic [31:0] dout0, dout1, out_data, out1;
  logic        out_valid, valid1, busy, busy1, done, done1;
  logic [31:0] rom [16];
  logic [31:0] q [$];
  logic [31:0] cap [256];
  int          cap_cyc [256];
  int          n_cmp = 0, n_bad = 0;
  int          xfers = 0, dones = 0, done_cyc = 0, cyc = 0;

  assign dout0 = rom[addr0];
  assign dout1 = rom[addr1];

  stf_gen u0 (
    .clk(clk), .phy_tx_arest(rst), .start(start), .stf_addr(addr0), .stf_dout(dout0),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  stf_gen #(.NUM_REP(2), .WIN_EN(0)) u1 (
    .clk(clk), .phy_tx_arest(rst), .start(start1), .stf_addr(addr1), .stf_dout(dout1),
    .out_data(out1), .out_valid(valid1), .out_ready(ready1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_sample(input int k, input int l, input bit win);
    logic [31:0] w;
    w = rom[k % 16];
    if (win && (k == 0 || k == l - 1)) w = {w[31], w[31:17], w[15], w[15:1]};
    return w;
  endfunction

  task automatic push_burst(input int l, input bit win);
    for (int k = 0; k < l; k++) q.push_back(exp_sample(k, l, win));
  endtask

  task automatic clear_stats();
    xfers = 0;
    dones = 0;
    done_cyc = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input string tag);
    int t = 0;
    while (xfers < n && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (xfers < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: transfers %0d, required %0d", tag, xfers, n);
    end
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (dones == 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (dones == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_done_timeout: no done pulse", tag);
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // scoreboard monitor: sampled mid-cycle, each transfer pops one expected sample
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_extra: unexpected sample %h at transfer %0d", out_data, xfers);
        end else begin
          logic [31:0] e;
          e = q.pop_front();
          if (out_data !== e) begin
            n_bad++;
            $display("FAIL sb_sample%0d: got %h, required %h", xfers, out_data, e);
          end
        end
        if (xfers < 256) begin
          cap[xfers] = out_data;
          cap_cyc[xfers] = cyc;
        end
        xfers++;
      end
      if (!out_valid) begin
        n_cmp++;
        if (out_data !== 32'd0) begin
          n_bad++;
          $display("FAIL idle_zero: out_data %h while out_valid=0, required 0", out_data);
        end
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    if (out_data !== 32'd0) begin n_bad++; $display("FAIL rst_data: got %h, required 0", out_data); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b, required 0", done); end
    if (addr0 !== 4'd0) begin n_bad++; $display("FAIL rst_addr: got %h, required 0", addr0); end
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    clear_stats();
    out_ready = 1'b1;
    push_burst(161, 1'b1);
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL burst_busy: got %b, required 1", busy); end
    wait_done("burst");
    n_cmp += 11;
    if (xfers != 161) begin n_bad++; $display("FAIL burst_count: got %0d, required 161", xfers); end
    if (cap[0] !== 32'h0179_0179) begin n_bad++; $display("FAIL burst_s0: got %h, required 01790179", cap[0]); end
    if (cap[1] !== 32'hfbd6_0000) begin n_bad++; $display("FAIL burst_s1: got %h, required fbd60000", cap[1]); end
    if (cap[2] !== 32'h02f2_fd0e) begin n_bad++; $display("FAIL burst_s2: got %h, required 02f2fd0e", cap[2]); end
    if (cap[16] !== 32'h02f2_02f2) begin n_bad++; $display("FAIL burst_s16: got %h, required 02f202f2", cap[16]); end
    if (cap[160] !== 32'h0179_0179) begin n_bad++; $display("FAIL burst_s160: got %h, required 01790179", cap[160]); end
    if (cap_cyc[160] - cap_cyc[0] != 160) begin n_bad++; $display("FAIL burst_rate: span %0d cycles, required 160", cap_cyc[160] - cap_cyc[0]); end
    if (dones != 1) begin n_bad++; $display("FAIL burst_dones: got %0d, required 1", dones); end
    if (done_cyc != cap_cyc[160] + 1) begin n_bad++; $display("FAIL burst_done_time: cycle %0d, required %0d", done_cyc, cap_cyc[160] + 1); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL burst_busy_end: got %b, required 0", busy); end
    if (q.size() != 0) begin n_bad++; $display("FAIL burst_sb_left: %0d left, required 0", q.size()); end
  endtask

  task automatic test_backpressure();
    clear_stats();
    push_burst(161, 1'b1);
    pulse_start();
    wait_xfers(5, "bp");
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp += 2;
      if (out_data !== 32'h042a_0000) begin n_bad++; $display("FAIL bp_hold_data: got %h, required 042a0000", out_data); end
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid: got %b, required 1", out_valid); end
    end
    out_ready = 1'b1;
    wait_done("bp");
    n_cmp += 3;
    if (cap[5] !== 32'h042a_0000) begin n_bad++; $display("FAIL bp_s5: got %h, required 042a0000", cap[5]); end
    if (cap[6] !== 32'hfd0e_02f2) begin n_bad++; $display("FAIL bp_s6: got %h, required fd0e02f2", cap[6]); end
    if (xfers != 161) begin n_bad++; $display("FAIL bp_count: got %0d, required 161", xfers); end
  endtask

  task automatic test_ignore_start();
    clear_stats();
    push_burst(161, 1'b1);
    pulse_start();
    wait_xfers(40, "ign");
    pulse_start();
    wait_done("ign");
    repeat (5) begin @(posedge clk); #1; end
    n_cmp += 3;
    if (xfers != 161) begin n_bad++; $display("FAIL ign_count: got %0d, required 161", xfers); end
    if (dones != 1) begin n_bad++; $display("FAIL ign_dones: got %0d, required 1", dones); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_busy: got %b, required 0", busy); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    push_burst(161, 1'b1);
    pulse_start();
    wait_xfers(70, "rmid");
    #2 rst = 1'b1;
    #1;
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b, required 0", out_valid); end
    if (out_data !== 32'd0) begin n_bad++; $display("FAIL rmid_data: got %h, required 0", out_data); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b, required 0", done); end
    if (addr0 !== 4'd0) begin n_bad++; $display("FAIL rmid_addr: got %h, required 0", addr0); end
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_stats();
    push_burst(161, 1'b1);
    pulse_start();
    wait_done("rmid");
    n_cmp += 3;
    if (cap[0] !== 32'h0179_0179) begin n_bad++; $display("FAIL rmid_s0: got %h, required 01790179", cap[0]); end
    if (xfers != 161) begin n_bad++; $display("FAIL rmid_count: got %0d, required 161", xfers); end
    if (dones != 1) begin n_bad++; $display("FAIL rmid_dones: got %0d, required 1", dones); end
  endtask

  task automatic test_nowin();
    logic [31:0] first = 32'd0, last = 32'd0, e;
    int k = 0, d1 = 0;
    ready1 = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (60) begin
      if (valid1) begin
        e = exp_sample(k, 32, 1'b0);
        n_cmp++;
        if (out1 !== e) begin n_bad++; $display("FAIL nowin_s%0d: got %h, required %h", k, out1, e); end
        if (k == 0) first = out1;
        if (k == 31) last = out1;
        k++;
      end
      if (done1) d1++;
      @(posedge clk); #1;
    end
    n_cmp += 4;
    if (k != 32) begin n_bad++; $display("FAIL nowin_count: got %0d, required 32", k); end
    if (first !== 32'h02f2_02f2) begin n_bad++; $display("FAIL nowin_s0: got %h, required 02f202f2", first); end
    if (last !== 32'h0000_fbd6) begin n_bad++; $display("FAIL nowin_s31: got %h, required 0000fbd6", last); end
    if (d1 != 1) begin n_bad++; $display("FAIL nowin_dones: got %0d, required 1", d1); end
  endtask

  initial begin
    rom[0] = 32'h02f2_02f2;  rom[1] = 32'hfbd6_0000;  rom[2] = 32'h02f2_fd0e;  rom[3] = 32'hfd0e_02f2;
    rom[4] = 32'h0000_042a;  rom[5] = 32'h042a_0000;  rom[6] = 32'hfd0e_02f2;  rom[7] = 32'hfbd6_0000;
    rom[8] = 32'h02f2_02f2;  rom[9] = 32'h0000_fbd6;  rom[10] = 32'hfd0e_fd0e; rom[11] = 32'hfd0e_02f2;
    rom[12] = 32'h0000_042a; rom[13] = 32'h02f2_fd0e; rom[14] = 32'hfd0e_fd0e; rom[15] = 32'h0000_fbd6;
    test_reset();
    test_burst();
    test_backpressure();
    test_ignore_start();
    test_reset_mid();
    test_nowin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
